// File: rtl/uart_packet_tx_if.sv
// Handshake bundle between a frame producer and uart_packet_tx:
// frame request (start/addr/len), payload stream, and status/line outputs.
interface uart_packet_tx_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       tx;

  modport master (
    output start, addr, len, in_data, in_valid,
    input  in_ready, busy, done, tx
  );

  modport slave (
    input  start, addr, len, in_data, in_valid,
    output in_ready, busy, done, tx
  );
endinterface

// File: rtl/uart_packet_tx.sv
// Packet framer + 8N1 UART serializer: sends DD, {0,addr}, len, payload, crc on tx.
// Optional macro UART_PKT_CRC_EN: XOR CRC byte when defined, constant 0xCC otherwise.
module uart_packet_tx #(
  parameter int SYS_CLK  = 100,
  parameter int BAUDRATE = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic            clk_100,
  input  logic            rst,
  uart_packet_tx_if.slave bus
);
  localparam int              DIV         = SYS_CLK * 1000000 / BAUDRATE;
  localparam int              BW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST   = BW'(DIV - 1);
  localparam logic [3:0]      GAP_LAST    = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [7:0]      PREFIX_BYTE = 8'hDD;

  typedef enum logic [2:0] {IDLE, PREFIX, ADDR, LEN, DATA, CRC} frame_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} ser_t;

  frame_t        frame_q, frame_d;
  ser_t          ser_q, ser_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    gap_q, gap_d;
  logic [7:0]    remain_q, remain_d;
  logic [7:0]    shift_q, shift_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          bit_end;
  logic          byte_done;
  logic          load;
  logic [7:0]    load_byte;
  logic          to_idle;
  logic [7:0]    crc_byte;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    frame_d   = frame_q;
    ser_d     = ser_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    remain_d  = remain_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    len_d     = len_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    byte_done = 1'b0;
    load      = 1'b0;
    load_byte = '0;
    to_idle   = 1'b0;

    unique case (ser_q)
      S_IDLE: ;
      S_START: begin
        if (bit_end) begin
          ser_d  = S_BITS;
          baud_d = '0;
          bit_d  = '0;
          tx_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_BITS: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            ser_d = S_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (GAP_BITS == 0) begin
            byte_done = 1'b1;
          end else begin
            ser_d = S_GAP;
            gap_d = '0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_GAP: begin
        if (bit_end) begin
          baud_d = '0;
          if (gap_q == GAP_LAST) byte_done = 1'b1;
          else                   gap_d = gap_q + 4'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: ;
    endcase

    // byte_done marks the last cycle of a byte; the next byte (or the
    // payload wait) is set up on that same edge so header bytes run back-to-back.
    unique case (frame_q)
      IDLE: begin
        if (bus.start) begin
          addr_d    = bus.addr;
          len_d     = bus.len;
          remain_d  = bus.len;
          busy_d    = 1'b1;
          frame_d   = PREFIX;
          load      = 1'b1;
          load_byte = PREFIX_BYTE;
        end
      end
      PREFIX: begin
        if (byte_done) begin
          frame_d   = ADDR;
          load      = 1'b1;
          load_byte = {1'b0, addr_q};
        end
      end
      ADDR: begin
        if (byte_done) begin
          frame_d   = LEN;
          load      = 1'b1;
          load_byte = len_q;
        end
      end
      LEN: begin
        if (byte_done) begin
          if (len_q == 8'd0) begin
            frame_d   = CRC;
            load      = 1'b1;
            load_byte = crc_byte;
          end else begin
            frame_d = DATA;
            to_idle = 1'b1;
          end
        end
      end
      DATA: begin
        if (ready_q && bus.in_valid) begin
          ready_d   = 1'b0;
          remain_d  = remain_q - 8'd1;
          load      = 1'b1;
          load_byte = bus.in_data;
        end else if (byte_done) begin
          if (remain_q == 8'd0) begin
            frame_d   = CRC;
            load      = 1'b1;
            load_byte = crc_byte;
          end else begin
            to_idle = 1'b1;
          end
        end
      end
      CRC: begin
        if (byte_done) begin
          frame_d = IDLE;
          ser_d   = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (to_idle) begin
      ser_d   = S_IDLE;
      ready_d = 1'b1;
      tx_d    = 1'b1;
    end
    if (load) begin
      ser_d   = S_START;
      baud_d  = '0;
      shift_d = load_byte;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      frame_q  <= IDLE;
      ser_q    <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      remain_q <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      ser_q    <= ser_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      remain_q <= remain_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

`ifdef UART_PKT_CRC_EN
  logic [7:0] crc_q;
  logic       crc_take;

  // Fold every byte except the prefix and the CRC itself into the running XOR.
  always_comb crc_take = load && (frame_d == ADDR || frame_d == LEN || frame_d == DATA);

  always_ff @(posedge clk_100) begin
    if (rst || (frame_q == IDLE && bus.start)) crc_q <= '0;
    else if (crc_take)                         crc_q <= crc_q ^ load_byte;
  end

  assign crc_byte = crc_q;
`else
  assign crc_byte = 8'hCC;
`endif

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = ready_q;
endmodule

// File: tb/tb_uart_packet_tx.sv
// Randomized bench for uart_packet_tx: a line receiver decodes tx, and a frame-level
// model predicts bytes, byte start cycles, handshake cycles and the done cycle.
module tb_uart_packet_tx;
  localparam int SYS_CLK  = 1;
  localparam int BAUDRATE = 125000;
  localparam int GAP_BITS = 1;
  localparam int DIV      = SYS_CLK * 1000000 / BAUDRATE;
  localparam int B        = (10 + GAP_BITS) * DIV;

  logic clk_100 = 1'b0;
  logic rst;
  always #5 clk_100 = ~clk_100;

  uart_packet_tx_if bus();

  uart_packet_tx #(
    .SYS_CLK (SYS_CLK),
    .BAUDRATE(BAUDRATE),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk_100(clk_100),
    .rst    (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line receiver: every sample of a bit must match its first sample.
  typedef struct {
    logic [7:0] data;
    int         t0;
    logic       ok;
  } rx_t;

  rx_t        rx_q[$];
  logic       rx_active = 1'b0;
  int         rx_cnt;
  int         rx_t0;
  logic [9:0] rx_bits;
  logic       rx_ok;
  int         ready_cycles = 0;

  always @(negedge clk_100) begin
    if (bus.in_ready === 1'b1) ready_cycles++;
    if (rst === 1'b1) begin
      rx_active = 1'b0;
    end else if (rx_active) begin
      if (rx_cnt % DIV == 0) rx_bits[rx_cnt / DIV] = bus.tx;
      else if (bus.tx !== rx_bits[rx_cnt / DIV]) rx_ok = 1'b0;
      if (rx_cnt == 10 * DIV - 1) begin
        rx_q.push_back('{data: rx_bits[8:1], t0: rx_t0, ok: rx_ok && !rx_bits[0] && rx_bits[9]});
        rx_active = 1'b0;
      end
      rx_cnt++;
    end else if (bus.tx === 1'b0) begin
      rx_active = 1'b1;
      rx_cnt    = 1;
      rx_t0     = cyc;
      rx_bits   = '0;
      rx_ok     = 1'b1;
    end
  end

  logic [7:0] pl[256];
  int         st[256];

  task automatic drive_payload(input logic [7:0] n, output int stall_low);
    int cnt, guard;
    stall_low = 0;
    for (int k = 0; k < int'(n); k++) begin
      cnt   = 0;
      guard = 0;
      if (st[k] == 0) begin
        bus.in_data  = pl[k];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_data  = 8'($urandom);
        bus.in_valid = 1'b0;
      end
      while (guard < 5 * B + st[k] + 4) begin
        if (bus.in_ready && !bus.in_valid) begin
          if (cnt == st[k]) begin
            bus.in_data  = pl[k];
            bus.in_valid = 1'b1;
          end else begin
            cnt++;
            if (bus.tx !== 1'b1) stall_low++;
          end
        end
        if (bus.in_ready && bus.in_valid) break;
        @(posedge clk_100); #1;
        guard++;
      end
      check_eq("hs_reached", 32'(bus.in_ready & bus.in_valid), 1);
      if (!(bus.in_ready && bus.in_valid)) break;
      @(posedge clk_100); #1;
      check_eq("ready_drop", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
    bus.in_valid = 1'b0;
  endtask

  // Starts a frame now and returns at the negedge of its done cycle.
  task automatic run_frame(input logic [6:0] a, input logic [7:0] n, input bit collide, input bit idle_after);
    int         c, rx_base, rdy_base, t, exp_done, exp_rdy, lim, guard, stall_low, extra;
    int         exp_t[$];
    logic [7:0] exp_b[$];
    logic [7:0] crc;

    c        = cyc;
    crc      = {1'b0, a} ^ n;
    exp_rdy  = 0;
    exp_b.push_back(8'hDD);
    exp_b.push_back({1'b0, a});
    exp_b.push_back(n);
    t = c + 1;
    exp_t.push_back(t);
    t += B; exp_t.push_back(t);
    t += B; exp_t.push_back(t);
    for (int k = 0; k < int'(n); k++) begin
      exp_b.push_back(pl[k]);
      crc ^= pl[k];
      t += B + 1 + st[k];
      exp_t.push_back(t);
      exp_rdy += 1 + st[k];
    end
`ifdef UART_PKT_CRC_EN
    exp_b.push_back(crc);
`else
    exp_b.push_back(8'hCC);
`endif
    t += B;
    exp_t.push_back(t);
    exp_done = t + B;

    rx_base  = rx_q.size();
    rdy_base = ready_cycles;
    bus.addr  = a;
    bus.len   = n;
    bus.start = 1'b1;
    @(posedge clk_100); #1;
    bus.start = 1'b0;
    check_eq("start_busy", 32'(bus.busy), 1);
    check_eq("start_tx", 32'(bus.tx), 0);
    bus.addr = 7'($urandom);
    bus.len  = 8'($urandom);

    fork
      drive_payload(n, stall_low);
      begin
        if (collide) begin
          repeat (B / 2) @(posedge clk_100);
          #1;
          check_eq("coll_busy", 32'(bus.busy), 1);
          bus.addr  = a ^ 7'h7F;
          bus.len   = n + 8'd3;
          bus.start = 1'b1;
          @(posedge clk_100); #1;
          bus.start = 1'b0;
        end
      end
    join

    lim   = exp_done - cyc + 2 * B;
    guard = 0;
    do begin
      @(negedge clk_100);
      guard++;
    end while (bus.done !== 1'b1 && guard < lim);
    check_eq("done_seen", 32'(bus.done), 1);
    check_eq("done_cycle", cyc, exp_done);
    check_eq("done_busy", 32'(bus.busy), 0);
    check_eq("byte_count", rx_q.size() - rx_base, exp_b.size());
    for (int i = 0; i < exp_b.size() && rx_base + i < rx_q.size(); i++) begin
      check_eq($sformatf("byte%0d_data", i), 32'(rx_q[rx_base + i].data), 32'(exp_b[i]));
      check_eq($sformatf("byte%0d_start", i), rx_q[rx_base + i].t0, exp_t[i]);
      check_eq($sformatf("byte%0d_shape", i), 32'(rx_q[rx_base + i].ok), 1);
    end
    check_eq("ready_cycles", ready_cycles - rdy_base, exp_rdy);
    check_eq("stall_tx_low", stall_low, 0);

    if (idle_after) begin
      extra = 0;
      repeat (3 * B) begin
        @(negedge clk_100);
        if (bus.done === 1'b1) extra++;
      end
      check_eq("extra_done", extra, 0);
      check_eq("extra_bytes", rx_q.size() - rx_base, exp_b.size());
      check_eq("idle_busy", 32'(bus.busy), 0);
      check_eq("idle_tx", 32'(bus.tx), 1);
    end
  endtask

  task automatic reset_mid_frame();
    int c, rx_base, rdy_base, dn;
    rx_base  = rx_q.size();
    rdy_base = ready_cycles;
    c        = cyc;
    bus.addr  = 7'h2A;
    bus.len   = 8'd3;
    bus.start = 1'b1;
    @(posedge clk_100); #1;
    bus.start = 1'b0;
    while (cyc < c + 1 + B + B / 2) begin
      @(posedge clk_100); #1;
    end
    rst = 1'b1;
    @(posedge clk_100); #1;
    rst = 1'b0;
    check_eq("rst_tx", 32'(bus.tx), 1);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_ready", 32'(bus.in_ready), 0);
    dn = 0;
    repeat (4 * B) begin
      @(negedge clk_100);
      if (bus.done === 1'b1) dn++;
    end
    check_eq("rst_no_done", dn, 0);
    check_eq("rst_bytes", rx_q.size() - rx_base, 1);
    check_eq("rst_ready_cycles", ready_cycles - rdy_base, 0);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.addr     = '0;
    bus.len      = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    check_eq("reset_tx", 32'(bus.tx), 1);
    check_eq("reset_busy", 32'(bus.busy), 0);
    check_eq("reset_done", 32'(bus.done), 0);
    check_eq("reset_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;

    pl[0] = 8'h16; pl[1] = 8'h1D; st[0] = 0; st[1] = 0;
    run_frame(7'h08, 8'd2, 1'b0, 1'b0);
    run_frame(7'h13, 8'd0, 1'b0, 1'b0);
    pl[0] = 8'($urandom); st[0] = 5000;
    run_frame(7'h55, 8'd1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pl[k] = 8'($urandom);
      st[k] = int'($urandom_range(0, 2));
    end
    run_frame(7'h21, 8'd4, 1'b1, 1'b1);
    reset_mid_frame();
    pl[0] = 8'h16; pl[1] = 8'h1D; st[0] = 0; st[1] = 0;
    run_frame(7'h08, 8'd2, 1'b0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(0, 12));
      for (int k = 0; k < n; k++) begin
        pl[k] = 8'($urandom);
        st[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      run_frame(7'($urandom), 8'(n), 1'b0, f == 7);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
